fir_preadd_sched: RTL and testbench

// - Time-multiplexed scheduler for one shared preadd-shift-accumulate unit in the symmetric FIR.
// - Sequences TAPS/2 symmetric tap pairs per input sample: PREADD (x[k]+x[TAPS-1-k]), SHIFT (<<h[k]), ACCUM.
// - Owns the sample delay line, the per-pair shift table and the accumulator.
// - Valid/ready on input samples and output results; one sample in flight at a time.

---
 rtl/fir_preadd_sched.sv | 129 ++++++++++++
 tb/tb_fir_preadd_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_preadd_sched.sv
// Scheduler for a shared preadd-shift-accumulate unit in a symmetric FIR filter.
// Processes TAPS/2 tap pairs per accepted sample, one sample in flight at a time.
module fir_preadd_sched #(
  parameter int unsigned     TAPS   = 8,
  parameter int unsigned     DW     = 8,
  parameter int unsigned     AW     = 12,
  parameter logic [TAPS-1:0] SHIFTS = 8'hE4,
  localparam int unsigned    P      = TAPS / 2,
  localparam int unsigned    KW     = (P > 1) ? $clog2(P) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [AW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic [KW-1:0] pair_idx,
  output logic [1:0]    stage
);

  localparam int unsigned IW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [2:0] {StIdle, StPre, StShf, StAcc, StDone} state_e;

  state_e          state_q;
  logic [DW-1:0]   d_q [TAPS];
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   t_q;
  logic [KW-1:0]   k_q;
  logic [AW-1:0]   out_data_q;
  logic            out_valid_q;
  logic [1:0]      stage_q;

  logic [IW-1:0]   k_lo;
  logic [IW-1:0]   k_hi;
  logic [DW:0]     pre_sum;
  logic [1:0]      sh;
  logic [AW-1:0]   shifted;
  logic [AW-1:0]   acc_sum;
  logic            last_pair;

  // Pair k combines taps k and TAPS-1-k, which share one coefficient.
  always_comb begin
    k_lo    = IW'(k_q);
    k_hi    = IW'(TAPS - 1) - k_lo;
    pre_sum = {1'b0, d_q[k_lo]} + {1'b0, d_q[k_hi]};
  end

  always_comb begin
    sh = '0;
    for (int unsigned p = 0; p < P; p++) begin
      if (k_q == KW'(p)) sh = SHIFTS[2*p +: 2];
    end
  end

  always_comb begin
    shifted   = t_q << sh;
    acc_sum   = acc_q + t_q;
    last_pair = (k_q == KW'(P - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      for (int i = 0; i < int'(TAPS); i++) d_q[i] <= '0;
      acc_q       <= '0;
      t_q         <= '0;
      k_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      stage_q     <= 2'd3;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            for (int i = int'(TAPS) - 1; i > 0; i--) d_q[i] <= d_q[i-1];
            d_q[0]  <= in_data;
            acc_q   <= '0;
            k_q     <= '0;
            stage_q <= 2'd0;
            state_q <= StPre;
          end
        end
        StPre: begin
          t_q     <= AW'(pre_sum);
          stage_q <= 2'd1;
          state_q <= StShf;
        end
        StShf: begin
          t_q     <= shifted;
          stage_q <= 2'd2;
          state_q <= StAcc;
        end
        StAcc: begin
          acc_q <= acc_sum;
          if (last_pair) begin
            out_data_q  <= acc_sum;
            out_valid_q <= 1'b1;
            k_q         <= '0;
            stage_q     <= 2'd3;
            state_q     <= StDone;
          end else begin
            k_q     <= k_q + 1'b1;
            stage_q <= 2'd0;
            state_q <= StPre;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pair_idx  = k_q;
  assign stage     = stage_q;

endmodule

// File: tb/tb_fir_preadd_sched.sv
// Directed-vector bench for fir_preadd_sched at default parameters.
// Expected results are hand-computed from the tap-pair shift table h = 0,1,2,3.
module tb_fir_preadd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_ready;
  logic        busy;
  logic [1:0]  pair_idx;
  logic [1:0]  stage;

  int errors = 0;
  int checks = 0;

  fir_preadd_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .pair_idx  (pair_idx),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one sample and waits (bounded) for its result; no checking here.
  task automatic run_sample(input logic [7:0] data, output logic [11:0] res, output bit ok);
    int n;
    ok  = 1'b0;
    res = '0;
    n   = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    in_valid = 1'b1;
    in_data  = data;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    if (out_valid) begin
      res = out_data;
      ok  = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    apply_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (stage !== 2'd3) begin errors++; $display("FAIL reset_stage got=%0d want=3", stage); end
    checks++; if (out_data !== 12'd0) begin errors++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    checks++; if (pair_idx !== 2'd0) begin errors++; $display("FAIL reset_pair_idx got=%0d want=0", pair_idx); end
  endtask

  task automatic test_impulse();
    logic [7:0]  stim [8];
    logic [11:0] exp  [8];
    logic [11:0] res;
    bit          ok;
    stim = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp  = '{12'd1, 12'd2, 12'd4, 12'd8, 12'd8, 12'd4, 12'd2, 12'd1};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_sample(stim[i], res, ok);
      checks++;
      if (!ok || res !== exp[i]) begin
        errors++;
        $display("FAIL impulse[%0d] got=%0d (valid=%b) want=%0d", i, res, ok, exp[i]);
      end
    end
  endtask

  // Runs straight after the impulse: the lone 1 sits in d[7] and drops out on the first 255.
  task automatic test_wrap();
    logic [11:0] res;
    bit          ok;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_sample(8'd255, res, ok);
      if (i == 0) begin
        checks++;
        if (!ok || res !== 12'd255) begin errors++; $display("FAIL wrap_first got=%0d want=255", res); end
      end else if (i == 1) begin
        checks++;
        if (!ok || res !== 12'd765) begin errors++; $display("FAIL wrap_second got=%0d want=765", res); end
      end else if (i == 7) begin
        checks++;
        if (!ok || res !== 12'd3554) begin errors++; $display("FAIL wrap_full got=%0d want=3554", res); end
      end
    end
  endtask

  // 13 edges counting the accept edge: 12 pair steps after it, then DONE.
  task automatic test_timing();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd9;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (stage !== 2'(i % 3) || pair_idx !== 2'(i / 3) || out_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL timing_walk[%0d] got stage=%0d pair=%0d ov=%b busy=%b want stage=%0d pair=%0d ov=0 busy=1",
                 i, stage, pair_idx, out_valid, busy, i % 3, i / 3);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 12'd9 || stage !== 2'd3 || pair_idx !== 2'd0) begin
      errors++;
      $display("FAIL timing_done got ov=%b data=%0d stage=%0d pair=%0d want ov=1 data=9 stage=3 pair=0",
               out_valid, out_data, stage, pair_idx);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL timing_handshake got ov=%b in_ready=%b want ov=0 in_ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] res;
    bit          ok;
    int          n;
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd7;
    step();
    // Keep offering a different sample; it must never be taken while busy.
    in_data = 8'd100;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 12'd7 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d] got ov=%b data=%0d in_ready=%b want ov=1 data=7 in_ready=0",
                 i, out_valid, out_data, in_ready);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release got ov=%b in_ready=%b want ov=0 in_ready=1", out_valid, in_ready);
    end
    // d = {0,7,0,...}: pair 1 carries 7 << 1.
    run_sample(8'd0, res, ok);
    checks++;
    if (!ok || res !== 12'd14) begin
      errors++;
      $display("FAIL backpressure_no_accept got=%0d want=14", res);
    end
  endtask

  task automatic test_midop_reset();
    logic [11:0] res;
    bit          ok;
    int          n;
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd5;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!(stage == 2'd2 && pair_idx == 2'd2) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (stage !== 2'd2 || pair_idx !== 2'd2) begin
      errors++;
      $display("FAIL midop_reach_acc2 got stage=%0d pair=%0d want stage=2 pair=2", stage, pair_idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || stage !== 2'd3 || out_data !== 12'd0) begin
      errors++;
      $display("FAIL midop_reset got in_ready=%b ov=%b busy=%b stage=%0d data=%0d want 1 0 0 3 0",
               in_ready, out_valid, busy, stage, out_data);
    end
    run_sample(8'd3, res, ok);
    checks++;
    if (!ok || res !== 12'd3) begin
      errors++;
      $display("FAIL midop_after_reset got=%0d want=3", res);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_impulse();
    test_wrap();
    test_timing();
    test_backpressure();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
